triangle_scan_gen: RTL and testbench
====================================

// Module: triangle_scan_gen
// PURPOSE
//   Raster stage directly upstream of BaricentricCoords. Accepts one triangle (3 vertices),
//   computes its bounding box clamped to the screen, then walks every pixel of the box
//   row-major, presenting evalX/evalY with a valid/ready handshake.
//   Also forwards the latched vertices, so the barycentric stage sees a stable triangle
//   for the whole scan. Signals completion with a one-cycle pulse.
// PARAMETERS
//   evalBits  10   width of evalX/evalY pixel coordinates
//   intBits   10   vertex coordinate is [intBits:0], two's-complement signed
//   SCREEN_W  640  visible width; x clamped to [0, SCREEN_W-1]
//   SCREEN_H  480  visible height; y clamped to [0, SCREEN_H-1]
// PORTS
//   clk        in   1            clock, rising edge
//   rst_n      in   1            asynchronous active-low reset
//   tri_valid  in   1            triangle offered on x_i/y_i
//   tri_ready  out  1            block can accept a triangle (state IDLE)
//   x_0..y_2   in   intBits+1    signed vertex coordinates, sampled on accept
//   vx_0..vy_2 out  intBits+1    latched vertices, stable from accept until next accept
//   evalX      out  evalBits     current pixel x
//   evalY      out  evalBits     current pixel y
//   pix_valid  out  1            evalX/evalY hold a pixel of the current box
//   pix_ready  in   1            downstream consumes the pixel this cycle
//   pix_last   out  1            current pixel is the final one of the box (qualified by pix_valid)
//   tri_done   out  1            one-cycle pulse: triangle finished (incl. empty box)
// BEHAVIOUR
//   - Reset: state IDLE; pix_valid=0, pix_last=0, tri_done=0, evalX=evalY=0, vx/vy=0;
//     tri_ready=1 (combinational: state==IDLE).
//   - States: IDLE -> SETUP -> SCAN -> DONE -> IDLE; SETUP -> DONE when box empty.
//   - IDLE: accept on tri_valid & tri_ready at edge N; latch vertices; go SETUP.
//   - SETUP (1 cycle): xmin/xmax/ymin/ymax = signed min/max of the 3 vertices.
//     Empty if xmax<0 | ymax<0 | xmin>SCREEN_W-1 | ymin>SCREEN_H-1. Otherwise clamp
//     each bound into the screen range. Load evalX=xmin, evalY=ymin. Go SCAN.
//   - Latency: first pix_valid=1 in cycle N+2; empty box: tri_done=1 in cycle N+2.
//   - SCAN: pix_valid=1. Advance only on pix_valid & pix_ready.
//     If evalX<xmax: evalX+1. Else evalX=xmin, evalY+1.
//     While stalled (pix_ready=0), evalX/evalY/pix_last hold exactly.
//   - pix_last = (evalX==xmax) & (evalY==ymax). Handshake on last pixel -> DONE;
//     pix_valid=0 the following cycle. No bubble between consecutive pixels when pix_ready=1.
//   - DONE (1 cycle): tri_done=1, then IDLE. Next triangle can be accepted the cycle after DONE.
//   - Pixel count = (xmax-xmin+1)*(ymax-ymin+1); single-pixel box presents pix_last on its only pixel.
//   - Arithmetic: compares are signed at intBits+1 bits. Clamped bounds are truncated to evalBits.
//   - tri_valid while not IDLE is ignored (not accepted, vertices unchanged).
//   - rst_n low mid-scan: immediately abandon the triangle; all outputs at reset values; no tri_done.
// TESTING
//   1. (10,10),(20,10),(10,20), pix_ready=1 -> 121 pixels (10,10),(11,10)..(20,20), one per cycle;
//      pix_last on (20,20); tri_done next cycle; first pix_valid 2 cycles after accept.
//   2. Same triangle, pix_ready pseudo-random 50% -> identical 121-pixel sequence, no skip/dup;
//      evalX/evalY stable on every stalled cycle.
//   3. Clamp: (-5,-5),(3,-5),(-5,3) -> 16 pixels (0,0)..(3,3).
//      Off-screen (700,10),(710,10),(700,20) -> 0 pixels, tri_done 2 cycles after accept.
//   4. All vertices (639,479) -> exactly one pixel (639,479) with pix_last=1, then tri_done.
//   5. rst_n pulsed low after 50th handshake -> pix_valid=0 asynchronously, tri_ready=1, no tri_done;
//      next triangle starts at its own xmin,ymin.
//   6. tri_valid held high with a different triangle during scan -> not accepted;
//      accepted the cycle after tri_done. vx/vy unchanged until then.

Source files
------------

// File: rtl/triangle_scan_gen_if.sv
// Triangle-in / pixel-out bundle between the setup stage, the scan generator and the
// barycentric stage.
interface triangle_scan_gen_if #(
  parameter int EVAL_BITS = 10,
  parameter int INT_BITS  = 10
);
  logic                       tri_valid;
  logic                       tri_ready;
  logic signed [INT_BITS:0]   x_0, y_0, x_1, y_1, x_2, y_2;
  logic signed [INT_BITS:0]   vx_0, vy_0, vx_1, vy_1, vx_2, vy_2;
  logic        [EVAL_BITS-1:0] evalX;
  logic        [EVAL_BITS-1:0] evalY;
  logic                       pix_valid;
  logic                       pix_ready;
  logic                       pix_last;
  logic                       tri_done;

  // master: the scan generator (accepts triangles, sources pixels)
  modport master (
    input  tri_valid, x_0, y_0, x_1, y_1, x_2, y_2, pix_ready,
    output tri_ready, vx_0, vy_0, vx_1, vy_1, vx_2, vy_2,
           evalX, evalY, pix_valid, pix_last, tri_done
  );

  modport slave (
    output tri_valid, x_0, y_0, x_1, y_1, x_2, y_2, pix_ready,
    input  tri_ready, vx_0, vy_0, vx_1, vy_1, vx_2, vy_2,
           evalX, evalY, pix_valid, pix_last, tri_done
  );
endinterface

// File: rtl/triangle_scan_gen.sv
// Triangle raster walker: clamps the vertex bounding box to the screen and streams its
// pixels row-major to the barycentric stage, holding the triangle stable meanwhile.
//   state | meaning
//   IDLE  | waiting for a triangle, tri_ready high
//   SETUP | vertex min/max, empty-box test, clamp to screen, load first pixel
//   SCAN  | presenting pixels, advance on pix_valid & pix_ready
//   DONE  | one-cycle tri_done pulse
module triangle_scan_gen #(
  parameter int EVAL_BITS = 10,
  parameter int INT_BITS  = 10,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input logic                 clk,
  input logic                 rst_n,
  triangle_scan_gen_if.master bus
);
  typedef logic signed [INT_BITS:0]  coord_t;
  typedef logic        [EVAL_BITS-1:0] pix_t;
  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

  localparam coord_t X_LIM = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_LIM = coord_t'(SCREEN_H - 1);

  state_t state, state_nxt;
  coord_t vx_q [3];
  coord_t vy_q [3];
  coord_t x_lo, x_hi, y_lo, y_hi;
  pix_t   xmin_c, xmax_c, ymin_c, ymax_c;
  pix_t   xmin, xmax, ymax, eval_x, eval_y;
  logic   box_empty, at_end, accept, advance;
  logic   tri_ready, pix_valid, pix_last, tri_done;

  // Bounds come from the latched vertices, so SETUP sees the accepted triangle.
  always_comb begin
    x_lo = vx_q[0];
    x_hi = vx_q[0];
    y_lo = vy_q[0];
    y_hi = vy_q[0];
    for (int i = 1; i < 3; i++) begin
      if (vx_q[i] < x_lo) x_lo = vx_q[i];
      if (vx_q[i] > x_hi) x_hi = vx_q[i];
      if (vy_q[i] < y_lo) y_lo = vy_q[i];
      if (vy_q[i] > y_hi) y_hi = vy_q[i];
    end
    box_empty = x_hi[INT_BITS] || y_hi[INT_BITS] || (x_lo > X_LIM) || (y_lo > Y_LIM);
    xmin_c = x_lo[INT_BITS] ? '0 : x_lo[EVAL_BITS-1:0];
    ymin_c = y_lo[INT_BITS] ? '0 : y_lo[EVAL_BITS-1:0];
    xmax_c = (x_hi > X_LIM) ? X_LIM[EVAL_BITS-1:0] : x_hi[EVAL_BITS-1:0];
    ymax_c = (y_hi > Y_LIM) ? Y_LIM[EVAL_BITS-1:0] : y_hi[EVAL_BITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tri_ready = (state == IDLE);
    pix_valid = (state == SCAN);
    tri_done  = (state == DONE);
    at_end    = (eval_x == xmax) && (eval_y == ymax);
    pix_last  = pix_valid && at_end;
    accept    = bus.tri_valid && tri_ready;
    advance   = pix_valid && bus.pix_ready;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = box_empty ? DONE : SCAN;
      SCAN:    if (advance && at_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
      xmin   <= '0;
      xmax   <= '0;
      ymax   <= '0;
      eval_x <= '0;
      eval_y <= '0;
    end else begin
      if (accept) begin
        vx_q[0] <= bus.x_0;
        vy_q[0] <= bus.y_0;
        vx_q[1] <= bus.x_1;
        vy_q[1] <= bus.y_1;
        vx_q[2] <= bus.x_2;
        vy_q[2] <= bus.y_2;
      end
      if (state == SETUP && !box_empty) begin
        xmin   <= xmin_c;
        xmax   <= xmax_c;
        ymax   <= ymax_c;
        eval_x <= xmin_c;
        eval_y <= ymin_c;
      end
      // The final pixel is left in place; SCAN exits on that handshake.
      if (advance && !at_end) begin
        if (eval_x < xmax) begin
          eval_x <= eval_x + 1'b1;
        end else begin
          eval_x <= xmin;
          eval_y <= eval_y + 1'b1;
        end
      end
    end
  end

  assign bus.tri_ready = tri_ready;
  assign bus.pix_valid = pix_valid;
  assign bus.pix_last  = pix_last;
  assign bus.tri_done  = tri_done;
  assign bus.evalX     = eval_x;
  assign bus.evalY     = eval_y;
  assign bus.vx_0      = vx_q[0];
  assign bus.vy_0      = vy_q[0];
  assign bus.vx_1      = vx_q[1];
  assign bus.vy_1      = vy_q[1];
  assign bus.vx_2      = vx_q[2];
  assign bus.vy_2      = vy_q[2];
endmodule

// File: tb/tb_triangle_scan_gen.sv
// Bench for triangle_scan_gen: table of directed triangles, reset/hold sequences and
// random triangles, all compared against a bounding-box pixel-list model.
module tb_triangle_scan_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  triangle_scan_gen_if #(.EVAL_BITS(10), .INT_BITS(10)) bus ();

  triangle_scan_gen #(
    .EVAL_BITS(10), .INT_BITS(10), .SCREEN_W(640), .SCREEN_H(480)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct { int x; int y; } pix_s;
  typedef struct {
    int x0, y0, x1, y1, x2, y2;
    int pct, npix, fx, fy, lx, ly;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  pix_s exp_q[$];
  int   nx[3];
  int   ny[3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int min3(input int a, input int b, input int c);
    int m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Expected pixel list: clamped bounding box, row-major.
  task automatic build_model(input int x0, y0, x1, y1, x2, y2);
    int xl, xh, yl, yh;
    exp_q.delete();
    xl = min3(x0, x1, x2);
    xh = max3(x0, x1, x2);
    yl = min3(y0, y1, y2);
    yh = max3(y0, y1, y2);
    if (xh < 0 || yh < 0 || xl > 639 || yl > 479) return;
    if (xl < 0) xl = 0;
    if (yl < 0) yl = 0;
    if (xh > 639) xh = 639;
    if (yh > 479) yh = 479;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++)
        exp_q.push_back('{x, y});
  endtask

  task automatic drive_tri(input int x0, y0, x1, y1, x2, y2);
    bus.x_0 = 11'(x0); bus.y_0 = 11'(y0);
    bus.x_1 = 11'(x1); bus.y_1 = 11'(y1);
    bus.x_2 = 11'(x2); bus.y_2 = 11'(y2);
  endtask

  // Entered and left at a negedge. keep_valid leaves tri_valid high with nx/ny offered.
  task automatic run_tri(input int x0, y0, x1, y1, x2, y2, input int pct,
                         input int abort_at, input bit keep_valid,
                         output int n, output int fx, output int fy,
                         output int lx, output int ly);
    int  hs = 0;
    int  budget;
    bit  exp_done = 1'b0;
    bit  got_done = 1'b0;
    bit  vok;
    build_model(x0, y0, x1, y1, x2, y2);
    n = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    chk("tri_ready_before_accept", int'(bus.tri_ready), 1);
    bus.tri_valid = 1'b1;
    drive_tri(x0, y0, x1, y1, x2, y2);
    @(negedge clk);
    if (keep_valid) drive_tri(nx[0], ny[0], nx[1], ny[1], nx[2], ny[2]);
    else bus.tri_valid = 1'b0;
    chk("setup_quiet", int'({bus.pix_valid, bus.tri_done, bus.tri_ready}), 0);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("empty_tri_done", int'(bus.tri_done), 1);
      chk("empty_no_pixel", int'(bus.pix_valid), 0);
    end else begin
      chk("first_pix_latency", int'(bus.pix_valid), 1);
      budget = 40 * exp_q.size() + 40;
      for (int c = 0; c < budget && !got_done; c++) begin
        vok = (int'(bus.vx_0) == x0) && (int'(bus.vy_0) == y0) &&
              (int'(bus.vx_1) == x1) && (int'(bus.vy_1) == y1) &&
              (int'(bus.vx_2) == x2) && (int'(bus.vy_2) == y2);
        chk("vertex_hold", int'(vok), 1);
        if (exp_done) begin
          chk("tri_done_after_last", int'(bus.tri_done), 1);
          chk("valid_drop_after_last", int'(bus.pix_valid), 0);
          got_done = 1'b1;
        end else begin
          chk("pix_valid", int'(bus.pix_valid), 1);
          chk("evalX", int'(bus.evalX), exp_q[0].x);
          chk("evalY", int'(bus.evalY), exp_q[0].y);
          chk("pix_last", int'(bus.pix_last), int'(exp_q.size() == 1));
          chk("no_early_done", int'(bus.tri_done), 0);
          bus.pix_ready = (int'($urandom_range(0, 99)) < pct);
          if (bus.pix_ready) begin
            if (n == 0) begin fx = exp_q[0].x; fy = exp_q[0].y; end
            lx = exp_q[0].x; ly = exp_q[0].y;
            n++; hs++;
            void'(exp_q.pop_front());
            exp_done = (exp_q.size() == 0);
          end
          @(negedge clk);
          if (abort_at > 0 && hs == abort_at) begin
            bus.pix_ready = 1'b0;
            return;
          end
        end
      end
      if (!got_done) chk("scan_timeout", 0, 1);
    end
    bus.pix_ready = 1'b0;
    @(negedge clk);
    chk("tri_ready_after_done", int'(bus.tri_ready), 1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   n, fx, fy, lx, ly;
    int   cx, cy;
    int   rx[3];
    int   ry[3];

    tbl[0] = '{10, 10, 20, 10, 10, 20, 100, 121, 10, 10, 20, 20};
    tbl[1] = '{10, 10, 20, 10, 10, 20,  50, 121, 10, 10, 20, 20};
    tbl[2] = '{-5, -5,  3, -5, -5,  3, 100,  16,  0,  0,  3,  3};
    tbl[3] = '{700, 10, 710, 10, 700, 20, 100, 0, -1, -1, -1, -1};
    tbl[4] = '{639, 479, 639, 479, 639, 479, 100, 1, 639, 479, 639, 479};
    tbl[5] = '{630, 470, 700, 470, 630, 500, 60, 100, 630, 470, 639, 479};
    tbl[6] = '{10, -10, 20, -3, 15, -20, 100, 0, -1, -1, -1, -1};
    tbl[7] = '{5, 7, 9, 7, 7, 7, 40, 5, 5, 7, 9, 7};

    bus.tri_valid = 1'b0;
    bus.pix_ready = 1'b0;
    drive_tri(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_tri_ready", int'(bus.tri_ready), 1);
    chk("reset_pix_valid", int'(bus.pix_valid), 0);
    chk("reset_pix_last", int'(bus.pix_last), 0);
    chk("reset_tri_done", int'(bus.tri_done), 0);
    chk("reset_evalX", int'(bus.evalX), 0);
    chk("reset_evalY", int'(bus.evalY), 0);
    chk("reset_vx_0", int'(bus.vx_0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_tri(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2,
              tbl[i].pct, 0, 1'b0, n, fx, fy, lx, ly);
      chk("tbl_count", n, tbl[i].npix);
      chk("tbl_first_x", fx, tbl[i].fx);
      chk("tbl_first_y", fy, tbl[i].fy);
      chk("tbl_last_x", lx, tbl[i].lx);
      chk("tbl_last_y", ly, tbl[i].ly);
    end

    // Reset after the 50th handshake abandons the scan.
    run_tri(10, 10, 20, 10, 10, 20, 100, 50, 1'b0, n, fx, fy, lx, ly);
    chk("abort_handshakes", n, 50);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_pix_valid", int'(bus.pix_valid), 0);
    chk("abort_tri_ready", int'(bus.tri_ready), 1);
    chk("abort_tri_done", int'(bus.tri_done), 0);
    chk("abort_evalX", int'(bus.evalX), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", int'(bus.tri_done), 0);
    end
    run_tri(30, 40, 35, 40, 30, 44, 100, 0, 1'b0, n, fx, fy, lx, ly);
    chk("post_abort_count", n, 30);
    chk("post_abort_first_x", fx, 30);
    chk("post_abort_first_y", fy, 40);

    // A second triangle offered throughout the scan is taken only after tri_done.
    nx[0] = 100; ny[0] = 200; nx[1] = 102; ny[1] = 200; nx[2] = 100; ny[2] = 201;
    run_tri(10, 10, 20, 10, 10, 20, 100, 0, 1'b1, n, fx, fy, lx, ly);
    chk("hold_first_count", n, 121);
    chk("hold_still_offered", int'(bus.tri_valid & bus.tri_ready), 1);
    run_tri(100, 200, 102, 200, 100, 201, 70, 0, 1'b0, n, fx, fy, lx, ly);
    chk("hold_second_count", n, 6);
    chk("hold_second_first_x", fx, 100);
    chk("hold_second_last_y", ly, 201);

    for (int t = 0; t < 12; t++) begin
      cx = int'($urandom_range(0, 700)) - 30;
      cy = int'($urandom_range(0, 540)) - 30;
      for (int v = 0; v < 3; v++) begin
        rx[v] = cx + int'($urandom_range(0, 16)) - 8;
        ry[v] = cy + int'($urandom_range(0, 16)) - 8;
      end
      run_tri(rx[0], ry[0], rx[1], ry[1], rx[2], ry[2],
              int'($urandom_range(30, 100)), 0, 1'b0, n, fx, fy, lx, ly);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
